dm_port_arbiter: RTL and testbench
==================================

# dm_port_arbiter

Shares the single data-memory port (word address, 4-bit byte-enable write, combinational read) between the CPU data side and one auxiliary master, such as a DMA or debug loader. Each master raises a request and holds it until acknowledged. The arbiter grants at most one access per cycle with round-robin priority, rejects out-of-range addresses, and returns registered read data one cycle after the grant. It sits between the CPU/bridge data outputs and the DM array.

## Interface
- DEPTH, 4096, number of 32-bit words in the data memory
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  CPU access request, held until m0_ack
- m0_addr  in  32  CPU byte address; bits [1:0] ignored
- m0_wdata  in  32  CPU write data
- m0_byteen  in  4  CPU byte enables; 0 means read
- m0_ack  out  1  CPU access performed this cycle
- m0_rdata  out  32  CPU read data, registered
- m0_rvalid  out  1  m0_rdata valid; one-cycle pulse
- m0_stall  out  1  m0_req & ~m0_ack
- m1_req, m1_addr, m1_wdata, m1_byteen, m1_ack, m1_rdata, m1_rvalid  same as m0_* for the auxiliary master
- mem_addr  out  32  word-aligned address to memory (addr & ~3)
- mem_wdata  out  32  write data to memory
- mem_byteen  out  4  byte enables to memory, written at the clk edge
- mem_rdata  in  32  combinational read data for mem_addr
- err  out  1  pulse: the granted access was out of range
- err_sticky  out  1  set by any err; cleared only by reset

## Operation
- Registered state:
  - last_gnt (0/1), reset value 1, so the CPU wins the first contention.
  - m0_rdata/m0_rvalid and m1_rdata/m1_rvalid.
  - err_sticky.
- Grant is combinational each cycle:
  - Only m0_req set: grant 0.
  - Only m1_req set: grant 1.
  - Both set: grant !last_gnt.
  - Neither set: no grant.
- last_gnt updates to the granted index at the clk edge. With no grant it holds.
- Granted master:
  - Its ack is 1 in that cycle, and mem_addr/mem_wdata come from it.
  - mem_byteen equals its byteen when in range, else 0.
- Ungranted cycles: mem_addr = 0, mem_wdata = 0, mem_byteen = 0, both acks 0.
- In range means (addr >> 2) < DEPTH.
  - Out-of-range access: still acked, write suppressed, err = 1 that cycle.
  - A read also returns rdata 0.
- Read (byteen == 0) granted in cycle N: at edge N, rdata_x <= mem_rdata (or 0 if out of range) and rvalid_x <= 1.
- Write granted: rvalid_x <= 0 and rdata_x holds its previous value.
- A non-granted master's rvalid drops to 0 next edge; its rdata holds.
- Masters must not change addr/wdata/byteen while req is high and ack is low. The arbiter does not check this.
- Back-to-back requests are allowed: a master keeping req high after ack starts a new access.

## Timing
- Reset (synchronous) clears m0_rvalid, m1_rvalid, both rdata (to 0) and err_sticky, and sets last_gnt = 1.
- While reset is high: acks = 0, mem_byteen = 0, err = 0, regardless of requests.
- Reset mid-access: an access acked in the reset cycle is not performed. The master must re-request.
- Latency:
  - Ack in the request cycle if granted.
  - rdata valid exactly 1 cycle after ack.
  - Worst-case wait under continuous contention is 1 cycle (strict alternation).
- Both masters continuously requesting produce grants 0,1,0,1,… after reset.
- Simultaneous write and read to the same address from different masters are serialized by grant order:
  - Reader granted after the writer sees new data.
  - Reader granted first sees old data.
- err is combinational in the grant cycle. err_sticky rises at the following edge.

## Test plan
- Reset, then m0 writes 0x12345678 byteen 4'b1111 to 0x0000_0010, then reads it -> m0_ack same cycles, read m0_rdata = 0x12345678 with m0_rvalid pulse one cycle after ack; m0_stall stays 0.
- Both request from the first cycle after reset: m0 writes 0xAAAA_AAAA @0x20, m1 reads @0x20 -> cycle 1 m0_ack, cycle 2 m1_ack, m1_rdata = 0xAAAA_AAAA; m1_stall-equivalent (m1_req & ~m1_ack) high in cycle 1.
- Both hold req for 6 cycles -> grants alternate 0,1,0,1,0,1; next cycle m1 alone -> granted immediately, last_gnt = 1.
- m1 partial write byteen 4'b0100 data 0x00EF_0000 over word 0x11223344 @0x40 -> read back 0x11EF3344.
- m0 write @0x0000_4000 (word 4096, out of range) with DEPTH = 4096 -> m0_ack = 1, mem_byteen = 0, err pulse, err_sticky = 1 until reset; read @0x4000 returns 0.
- Assert reset in the cycle m0 is acked for a write @0x50 -> memory unchanged, all rvalid = 0, err_sticky = 0, and the first contention after reset is granted to m0.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - two-master round-robin arbiter for the data-memory port
//
// Grants one of two masters (m0 = CPU data side, m1 = auxiliary master) access
// to a single data-memory port each cycle. Out-of-range accesses are acked but
// suppressed and flagged on err / err_sticky. Read data returns registered,
// one cycle after the ack.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   mX_req/addr/wdata/byteen   request from master X (byteen == 0 means read)
//   mX_ack                     access performed this cycle
//   mX_rdata/mX_rvalid         registered read data, valid pulse one cycle after ack
//   m0_stall                   m0_req & ~m0_ack
//   mem_addr/wdata/byteen      word-aligned port to the memory array
//   mem_rdata                  combinational read data for mem_addr
//   err, err_sticky            out-of-range pulse and its reset-only-cleared flag
module dm_port_arbiter #(
   parameter int DEPTH = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_byteen,
   output logic        m0_ack,
   output logic [31:0] m0_rdata,
   output logic        m0_rvalid,
   output logic        m0_stall,
   input  logic        m1_req,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_byteen,
   output logic        m1_ack,
   output logic [31:0] m1_rdata,
   output logic        m1_rvalid,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_byteen,
   input  logic [31:0] mem_rdata,
   output logic        err,
   output logic        err_sticky
);

   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   logic        last_gnt;
   logic        gnt_any;
   logic        gnt_idx;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [3:0]  sel_byteen;
   logic        in_range;
   logic        sel_read;
   logic [31:0] rd_data;

   always_comb begin
      // No grant while reset is high, so nothing acked in that cycle is performed.
      gnt_any    = ~reset & (m0_req | m1_req);
      // Under contention the master not granted last time wins.
      gnt_idx    = (m0_req & m1_req) ? ~last_gnt : m1_req;
      sel_addr   = gnt_idx ? m1_addr   : m0_addr;
      sel_wdata  = gnt_idx ? m1_wdata  : m0_wdata;
      sel_byteen = gnt_idx ? m1_byteen : m0_byteen;
      in_range   = {2'b00, sel_addr[31:2]} < DEPTH_W;
      sel_read   = (sel_byteen == 4'b0000);
      rd_data    = in_range ? mem_rdata : 32'h0;

      m0_ack     = gnt_any & ~gnt_idx;
      m1_ack     = gnt_any &  gnt_idx;
      m0_stall   = m0_req & ~m0_ack;
      mem_addr   = gnt_any ? {sel_addr[31:2], 2'b00} : 32'h0;
      mem_wdata  = gnt_any ? sel_wdata : 32'h0;
      mem_byteen = (gnt_any & in_range) ? sel_byteen : 4'b0000;
      err        = gnt_any & ~in_range;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_gnt   <= 1'b1;
         m0_rdata   <= 32'h0;
         m0_rvalid  <= 1'b0;
         m1_rdata   <= 32'h0;
         m1_rvalid  <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         if (gnt_any) begin
            last_gnt <= gnt_idx;
         end
         // rvalid pulses only for a granted read; rdata holds otherwise.
         m0_rvalid <= m0_ack & sel_read;
         m1_rvalid <= m1_ack & sel_read;
         if (m0_ack && sel_read) begin
            m0_rdata <= rd_data;
         end
         if (m1_ack && sel_read) begin
            m1_rdata <= rd_data;
         end
         if (err) begin
            err_sticky <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb/tb_dm_port_arbiter.sv - directed self-checking bench for dm_port_arbiter
module tb_dm_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m1_req;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_byteen, m1_byteen;
   logic        m0_ack, m0_rvalid, m0_stall, m1_ack, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_byteen;
   logic        err, err_sticky;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem [0:4095];

   always #5 clk = ~clk;

   dm_port_arbiter #(.DEPTH(4096)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_byteen(m0_byteen),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_stall(m0_stall),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_byteen(m1_byteen),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byteen(mem_byteen),
      .mem_rdata(mem_rdata), .err(err), .err_sticky(err_sticky)
   );

   // Bench-side memory array; out-of-range reads return a marker the DUT must not pass on.
   always_comb begin
      mem_rdata = 32'hDEAD_BEEF;
      if (mem_addr[31:2] < 30'd4096) mem_rdata = mem[mem_addr[13:2]];
   end

   always @(posedge clk) begin
      if (mem_addr[31:2] < 30'd4096) begin
         for (int b = 0; b < 4; b++)
            if (mem_byteen[b]) mem[mem_addr[13:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      m0_req = 0; m1_req = 0; m0_byteen = 0; m1_byteen = 0;
      m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
   endtask

   task automatic do_reset;
      idle();
      reset = 1;
      tick();
      reset = 0;
   endtask

   task automatic test_reset;
      reset = 1;
      m0_req = 1; m0_addr = 32'h10; m0_byteen = 4'h0;
      m1_req = 1; m1_addr = 32'h4000; m1_byteen = 4'hF;
      @(negedge clk);
      checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL rst_m0_ack got=%b exp=0", m0_ack); end
      checks++; if (m1_ack !== 1'b0) begin errors++; $display("FAIL rst_m1_ack got=%b exp=0", m1_ack); end
      checks++; if (mem_byteen !== 4'h0) begin errors++; $display("FAIL rst_byteen got=%h exp=0", mem_byteen); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err); end
      tick();
      checks++; if ({m0_rvalid, m1_rvalid, err_sticky} !== 3'b000) begin errors++; $display("FAIL rst_regs got=%b exp=000", {m0_rvalid, m1_rvalid, err_sticky}); end
      checks++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h/%h exp=0/0", m0_rdata, m1_rdata); end
      idle();
      reset = 0;
   endtask

   task automatic test_single;
      m0_req = 1; m0_addr = 32'h10; m0_wdata = 32'h1234_5678; m0_byteen = 4'hF;
      @(negedge clk);
      checks++; if (m0_ack !== 1'b1 || m0_stall !== 1'b0) begin errors++; $display("FAIL single_wr_ack got=%b%b exp=10", m0_ack, m0_stall); end
      checks++; if (mem_addr !== 32'h10 || mem_byteen !== 4'hF) begin errors++; $display("FAIL single_wr_port got=%h/%h exp=10/f", mem_addr, mem_byteen); end
      tick();
      checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL single_wr_rvalid got=%b exp=0", m0_rvalid); end
      m0_byteen = 4'h0; m0_addr = 32'h13;
      @(negedge clk);
      checks++; if (m0_ack !== 1'b1 || m0_stall !== 1'b0 || mem_addr !== 32'h10) begin errors++; $display("FAIL single_rd_ack got=%b%b/%h exp=10/10", m0_ack, m0_stall, mem_addr); end
      tick();
      checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h1234_5678) begin errors++; $display("FAIL single_rd_data got=%b/%h exp=1/12345678", m0_rvalid, m0_rdata); end
      idle();
      tick();
      checks++; if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h1234_5678) begin errors++; $display("FAIL single_rvalid_drop got=%b/%h exp=0/12345678", m0_rvalid, m0_rdata); end
   endtask

   task automatic test_rw_contention;
      do_reset();
      m0_req = 1; m0_addr = 32'h20; m0_wdata = 32'hAAAA_AAAA; m0_byteen = 4'hF;
      m1_req = 1; m1_addr = 32'h20; m1_byteen = 4'h0;
      @(negedge clk);
      checks++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin errors++; $display("FAIL rw_c1_acks got=%b%b exp=10", m0_ack, m1_ack); end
      checks++; if ((m1_req & ~m1_ack) !== 1'b1) begin errors++; $display("FAIL rw_m1_stall got=%b exp=1", m1_req & ~m1_ack); end
      tick();
      m0_req = 0; m0_byteen = 0;
      @(negedge clk);
      checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b1) begin errors++; $display("FAIL rw_c2_acks got=%b%b exp=01", m0_ack, m1_ack); end
      tick();
      checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hAAAA_AAAA) begin errors++; $display("FAIL rw_m1_rdata got=%b/%h exp=1/aaaaaaaa", m1_rvalid, m1_rdata); end
      idle();
   endtask

   task automatic test_alternate;
      m0_req = 1; m0_addr = 32'h20; m0_byteen = 0;
      m1_req = 1; m1_addr = 32'h20; m1_byteen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++; if (m0_ack !== ((i % 2) == 0) || m1_ack !== ((i % 2) == 1)) begin errors++; $display("FAIL alt_cycle%0d got=%b%b exp=%b%b", i, m0_ack, m1_ack, (i % 2) == 0, (i % 2) == 1); end
         tick();
      end
      m0_req = 0;
      @(negedge clk);
      checks++; if (m1_ack !== 1'b1) begin errors++; $display("FAIL alt_m1_alone got=%b exp=1", m1_ack); end
      tick();
      m0_req = 1;
      @(negedge clk);
      checks++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin errors++; $display("FAIL alt_after_m1 got=%b%b exp=10", m0_ack, m1_ack); end
      tick();
      idle();
   endtask

   task automatic test_partial_write;
      m1_req = 1; m1_addr = 32'h40; m1_wdata = 32'h1122_3344; m1_byteen = 4'hF;
      tick();
      m1_wdata = 32'h00EF_0000; m1_byteen = 4'b0100;
      @(negedge clk);
      checks++; if (m1_ack !== 1'b1 || mem_byteen !== 4'b0100) begin errors++; $display("FAIL pw_port got=%b/%h exp=1/4", m1_ack, mem_byteen); end
      tick();
      m1_byteen = 4'h0;
      tick();
      checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h11EF_3344) begin errors++; $display("FAIL pw_readback got=%b/%h exp=1/11ef3344", m1_rvalid, m1_rdata); end
      idle();
   endtask

   task automatic test_out_of_range;
      m0_req = 1; m0_addr = 32'h4000; m0_wdata = 32'h5A5A_5A5A; m0_byteen = 4'hF;
      @(negedge clk);
      checks++; if (m0_ack !== 1'b1 || mem_byteen !== 4'h0 || err !== 1'b1) begin errors++; $display("FAIL oor_wr got=%b/%h/%b exp=1/0/1", m0_ack, mem_byteen, err); end
      checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL oor_sticky_early got=%b exp=0", err_sticky); end
      tick();
      checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL oor_sticky_set got=%b exp=1", err_sticky); end
      m0_byteen = 4'h0;
      @(negedge clk);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_rd_err got=%b exp=1", err); end
      tick();
      checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0) begin errors++; $display("FAIL oor_rd_data got=%b/%h exp=1/0", m0_rvalid, m0_rdata); end
      idle();
      @(negedge clk);
      checks++; if (err !== 1'b0 || err_sticky !== 1'b1) begin errors++; $display("FAIL oor_idle got=%b%b exp=01", err, err_sticky); end
      tick();
   endtask

   task automatic test_reset_mid;
      m0_req = 1; m0_addr = 32'h50; m0_wdata = 32'h5555_AAAA; m0_byteen = 4'hF;
      tick();
      m0_byteen = 4'h0;
      tick();
      checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h5555_AAAA) begin errors++; $display("FAIL rm_pre_read got=%b/%h exp=1/5555aaaa", m0_rvalid, m0_rdata); end
      reset = 1;
      m0_wdata = 32'hFFFF_FFFF; m0_byteen = 4'hF;
      @(negedge clk);
      checks++; if (m0_ack !== 1'b0 || mem_byteen !== 4'h0) begin errors++; $display("FAIL rm_blocked got=%b/%h exp=0/0", m0_ack, mem_byteen); end
      tick();
      reset = 0;
      checks++; if ({m0_rvalid, m1_rvalid, err_sticky} !== 3'b000) begin errors++; $display("FAIL rm_regs got=%b exp=000", {m0_rvalid, m1_rvalid, err_sticky}); end
      m0_byteen = 4'h0;
      m1_req = 1; m1_addr = 32'h50; m1_byteen = 4'h0;
      @(negedge clk);
      checks++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin errors++; $display("FAIL rm_first_gnt got=%b%b exp=10", m0_ack, m1_ack); end
      tick();
      checks++; if (m0_rdata !== 32'h5555_AAAA) begin errors++; $display("FAIL rm_mem_kept got=%h exp=5555aaaa", m0_rdata); end
      idle();
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
      reset = 1;
      idle();
      test_reset();
      test_single();
      test_rw_contention();
      test_alternate();
      test_partial_write();
      test_out_of_range();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
